mult_sequencer: RTL and testbench

//   Control FSM for the serial-parallel multiplier. Takes debounced button levels, edge-detects

---
 rtl/mult_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_mult_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Control sequencer for the serial-parallel multiplier: edge-detects the
// debounced buttons, latches operands, steps the datapath through
// clear/load and WIDTH serial shift cycles, captures the product and
// tracks the display scroll position.
module mult_sequencer #(
    parameter int WIDTH      = 8,
    parameter int DP_LAT     = 1,
    parameter int SCROLL_MAX = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_start,
    input  logic                 btn_left,
    input  logic                 btn_right,
    input  logic [WIDTH-1:0]     sw_a,
    input  logic [WIDTH-1:0]     sw_b,
    input  logic [2*WIDTH-1:0]   dp_product,
    output logic                 dp_clear,
    output logic                 dp_load,
    output logic                 dp_shift,
    output logic [WIDTH-1:0]     dp_a,
    output logic                 dp_ser_bit,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           scroll_pos
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int LAT_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Button bit order: [0]=start, [1]=left, [2]=right
    logic [2:0] btn_vec;
    assign btn_vec = {btn_right, btn_left, btn_start};

    state_t               state_q, state_d;
    logic [2:0]           prev_q, prev_d;
    logic [2:0]           edge_q, edge_d;
    logic [WIDTH-1:0]     dp_a_q, dp_a_d;
    logic [WIDTH-1:0]     b_sr_q, b_sr_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [LAT_W-1:0]     cap_cnt_q, cap_cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [1:0]           scroll_q, scroll_d;
    logic                 dp_clear_q, dp_clear_d;
    logic                 dp_load_q, dp_load_d;
    logic                 dp_shift_q, dp_shift_d;
    logic                 dp_ser_bit_q, dp_ser_bit_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic edge_start, edge_left, edge_right;
    assign edge_start = edge_q[0];
    assign edge_left  = edge_q[1];
    assign edge_right = edge_q[2];

    // Next-state, datapath bookkeeping and registered output decode
    always_comb begin
        state_d      = state_q;
        prev_d       = btn_vec;
        // History resets to 1, so a button held through reset gives no edge
        edge_d       = btn_vec & ~prev_q;
        dp_a_d       = dp_a_q;
        b_sr_d       = b_sr_q;
        bit_cnt_d    = bit_cnt_q;
        cap_cnt_d    = cap_cnt_q;
        product_d    = product_q;
        scroll_d     = scroll_q;

        case (state_q)
            S_IDLE: begin
                if (edge_start) begin
                    dp_a_d   = sw_a;
                    b_sr_d   = sw_b;
                    scroll_d = 2'd0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                bit_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                if (bit_cnt_q == CNT_W'(WIDTH - 1)) begin
                    cap_cnt_d = '0;
                    state_d   = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                cap_cnt_d = cap_cnt_q + LAT_W'(1);
                if (cap_cnt_q == LAT_W'(DP_LAT - 1)) begin
                    product_d = dp_product;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                if (edge_start) begin
                    dp_a_d   = sw_a;
                    b_sr_d   = sw_b;
                    scroll_d = 2'd0;
                    state_d  = S_LOAD;
                end else if (edge_left && !edge_right) begin
                    if (scroll_q != 2'd0)
                        scroll_d = scroll_q - 2'd1;
                end else if (edge_right && !edge_left) begin
                    if (scroll_q != 2'(SCROLL_MAX))
                        scroll_d = scroll_q + 2'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs follow the state being entered so they line up with it
        dp_clear_d   = (state_d == S_LOAD);
        dp_load_d    = (state_d == S_LOAD);
        dp_shift_d   = (state_d == S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_CAPTURE);
        done_d       = (state_d == S_DONE);
        dp_ser_bit_d = 1'b0;
        // Present the next multiplier bit for the coming RUN cycle, LSB first
        if (state_d == S_RUN) begin
            dp_ser_bit_d = b_sr_q[0];
            b_sr_d       = b_sr_q >> 1;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prev_q       <= 3'b111;
            edge_q       <= 3'b000;
            dp_a_q       <= '0;
            b_sr_q       <= '0;
            bit_cnt_q    <= '0;
            cap_cnt_q    <= '0;
            product_q    <= '0;
            scroll_q     <= 2'd0;
            dp_clear_q   <= 1'b0;
            dp_load_q    <= 1'b0;
            dp_shift_q   <= 1'b0;
            dp_ser_bit_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            edge_q       <= edge_d;
            dp_a_q       <= dp_a_d;
            b_sr_q       <= b_sr_d;
            bit_cnt_q    <= bit_cnt_d;
            cap_cnt_q    <= cap_cnt_d;
            product_q    <= product_d;
            scroll_q     <= scroll_d;
            dp_clear_q   <= dp_clear_d;
            dp_load_q    <= dp_load_d;
            dp_shift_q   <= dp_shift_d;
            dp_ser_bit_q <= dp_ser_bit_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign dp_clear   = dp_clear_q;
    assign dp_load    = dp_load_q;
    assign dp_shift   = dp_shift_q;
    assign dp_a       = dp_a_q;
    assign dp_ser_bit = dp_ser_bit_q;
    assign product    = product_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign scroll_pos = scroll_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: directed and random multiplications against a
// shift-and-add datapath model and plain a*b expectations, plus button,
// scroll and reset corner cases.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_start, btn_left, btn_right;
    logic [7:0]  sw_a, sw_b;
    logic [15:0] dp_product;
    logic        dp_clear, dp_load, dp_shift, dp_ser_bit;
    logic [7:0]  dp_a;
    logic [15:0] product;
    logic        busy, done;
    logic [1:0]  scroll_pos;

    int n_checks = 0;
    int n_pass   = 0;

    mult_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .sw_a       (sw_a),
        .sw_b       (sw_b),
        .dp_product (dp_product),
        .dp_clear   (dp_clear),
        .dp_load    (dp_load),
        .dp_shift   (dp_shift),
        .dp_a       (dp_a),
        .dp_ser_bit (dp_ser_bit),
        .product    (product),
        .busy       (busy),
        .done       (done),
        .scroll_pos (scroll_pos)
    );

    always #5 clk = ~clk;

    // Datapath model: accumulate dp_a weighted by bit position; the
    // accumulator itself is the single output register stage
    logic [15:0] acc;
    int          idx;
    logic        ser_hist[$];
    assign dp_product = acc;

    always @(posedge clk) begin
        if (rst || dp_clear) begin
            acc <= 16'd0;
            idx <= 0;
        end else if (dp_shift) begin
            if (dp_ser_bit)
                acc <= acc + (16'(dp_a) << idx);
            idx <= idx + 1;
            ser_hist.push_back(dp_ser_bit);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Launch one multiplication and follow it until done rises (bounded)
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output int busy_cyc,
                          output logic [7:0] bits, output int shifts);
        int  s0;
        int  cyc;
        bit  seen_busy;
        s0 = ser_hist.size();
        @(negedge clk);
        sw_a = a; sw_b = b; btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        cyc = 1; busy_cyc = 0; seen_busy = 0;
        if (busy) begin busy_cyc++; seen_busy = 1; end
        while (!(done && seen_busy) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy) begin busy_cyc++; seen_busy = 1; end
        end
        lat    = cyc - 1;
        shifts = ser_hist.size() - s0;
        bits   = 8'd0;
        for (int i = 0; i < 8 && i < shifts; i++)
            bits[i] = ser_hist[s0 + i];
        $display("op a=%0d b=%0d latency=%0d busy=%0d shifts=%0d product=%0d",
                 a, b, lat, busy_cyc, shifts, product);
    endtask

    // One-cycle press and release of a scroll button pattern
    task automatic press_scroll(input logic l, input logic r);
        @(negedge clk);
        btn_left = l; btn_right = r;
        @(negedge clk);
        btn_left = 1'b0; btn_right = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int          lat, bc, sh;
        logic [7:0]  bits;
        logic [7:0]  ra, rb;
        int          scroll_exp;

        rst = 1'b1; btn_start = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        sw_a = 8'd0; sw_b = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_product", 32'(product), 32'd0);
        check("reset_scroll", 32'(scroll_pos), 32'd0);
        check("reset_ctrl", 32'({dp_clear, dp_load, dp_shift, dp_ser_bit}), 32'd0);
        check("reset_dp_a", 32'(dp_a), 32'd0);
        $display("reset state checked");

        // 13 x 11: bit stream, latency, busy window
        run_op(8'd13, 8'd11, lat, bc, bits, sh);
        check("t1_latency", 32'(lat), 32'd11);
        check("t1_busy_cycles", 32'(bc), 32'd10);
        check("t1_ser_bits", 32'(bits), 32'd11);
        check("t1_shifts", 32'(sh), 32'd8);
        check("t1_product", 32'(product), 32'(13 * 11));

        // Extremes
        run_op(8'd255, 8'd255, lat, bc, bits, sh);
        check("t2_max_product", 32'(product), 32'd65025);
        run_op(8'd0, 8'd200, lat, bc, bits, sh);
        check("t2_zero_product", 32'(product), 32'd0);

        // Random operands
        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(ra, rb, lat, bc, bits, sh);
            check("rand_product", 32'(product), 32'(ra) * 32'(rb));
            check("rand_ser_bits", 32'(bits), 32'(rb));
            check("rand_latency", 32'(lat), 32'd11);
        end

        // Start held across reset release: no run until re-pressed
        @(negedge clk);
        btn_start = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_held_no_busy", 32'(busy), 32'd0);
        check("t3_held_no_done", 32'(done), 32'd0);
        btn_start = 1'b0;
        run_op(8'd7, 8'd9, lat, bc, bits, sh);
        check("t3_rerun_product", 32'(product), 32'd63);
        $display("held-start case done");

        // Second start and operand change during RUN are ignored
        begin
            int s0, cyc;
            bit seen_busy;
            s0 = ser_hist.size();
            @(negedge clk);
            sw_a = 8'd21; sw_b = 8'd19; btn_start = 1'b1;
            @(negedge clk);
            btn_start = 1'b0;
            repeat (3) @(negedge clk);
            btn_start = 1'b1; sw_b = 8'd250; sw_a = 8'd3;
            @(negedge clk);
            btn_start = 1'b0;
            cyc = 0; seen_busy = 1;
            while (!done && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("t4_shift_count", 32'(ser_hist.size() - s0), 32'd8);
            check("t4_product_latched", 32'(product), 32'(21 * 19));
            repeat (3) @(negedge clk);
            check("t4_not_queued", 32'(busy), 32'd0);
            $display("mid-run start/operand change case done");
        end

        // Scroll handling in DONE
        scroll_exp = 0;
        for (int k = 0; k < 4; k++) begin
            press_scroll(1'b0, 1'b1);
            scroll_exp = (scroll_exp < 2) ? scroll_exp + 1 : 2;
            check("t5_right", 32'(scroll_pos), 32'(scroll_exp));
            $display("right press -> scroll_pos=%0d", scroll_pos);
        end
        press_scroll(1'b1, 1'b1);
        check("t5_both", 32'(scroll_pos), 32'(scroll_exp));
        for (int k = 0; k < 3; k++) begin
            press_scroll(1'b1, 1'b0);
            scroll_exp = (scroll_exp > 0) ? scroll_exp - 1 : 0;
            check("t5_left", 32'(scroll_pos), 32'(scroll_exp));
            $display("left press -> scroll_pos=%0d", scroll_pos);
        end
        press_scroll(1'b0, 1'b1);
        check("t5_right_again", 32'(scroll_pos), 32'd1);
        run_op(8'd5, 8'd6, lat, bc, bits, sh);
        check("t5_start_clears_scroll", 32'(scroll_pos), 32'd0);
        check("t5_product", 32'(product), 32'd30);

        // Reset during RUN cycle 5
        @(negedge clk);
        sw_a = 8'd99; sw_b = 8'd77; btn_start = 1'b1;
        @(negedge clk);
        btn_start = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_in_run", 32'(dp_shift), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_shift", 32'(dp_shift), 32'd0);
        check("t6_product", 32'(product), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("t6_stays_idle", 32'(busy), 32'd0);
        $display("reset-during-run case done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
